// File: rtl/serial_prod_collector.sv
// Deserializes an LSB-first bit-serial product into parallel words, aligned to a
// frame start pulse, and buffers completed words in a 2-entry valid/ready FIFO.
module serial_prod_collector #(
  parameter int PROD_W = 8,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ser_in,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              overflow,
  output logic              frame_err
);

  // state | meaning
  // IDLE  | waiting for start
  // ALIGN | burning LAT-1 edges of multiplier latency
  // SHIFT | sampling product bits 0..PROD_W-1
  typedef enum logic [1:0] {IDLE, ALIGN, SHIFT} state_t;

  localparam int CW = (PROD_W > 1) ? $clog2(PROD_W) : 1;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [1:0]        align_cnt;
  logic [PROD_W-1:0] sreg;
  logic [PROD_W-1:0] word;
  logic [PROD_W-1:0] tail;
  logic [1:0]        count;
  logic              last;
  logic              push;
  logic              pop;

  // Completed word includes the bit being sampled on the final edge
  always_comb begin
    word      = sreg;
    word[cnt] = ser_in;
  end

  assign last      = (state == SHIFT) && (cnt == CW'(PROD_W - 1));
  assign push      = last;
  assign pop       = out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign out_valid = (count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      align_cnt <= '0;
      sreg      <= '0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            if (LAT == 1) begin
              state <= SHIFT;
            end else begin
              state     <= ALIGN;
              align_cnt <= 2'(LAT - 2);
            end
          end
        end
        ALIGN: begin
          if (start) frame_err <= 1'b1;
          if (align_cnt == 2'd0) state <= SHIFT;
          else align_cnt <= align_cnt - 2'd1;
        end
        SHIFT: begin
          sreg[cnt] <= ser_in;
          if (last) begin
            cnt <= '0;
            // A start on the final-bit edge opens the next frame with no gap
            if (!start) begin
              state <= IDLE;
            end else if (LAT == 1) begin
              state <= SHIFT;
            end else begin
              state     <= ALIGN;
              align_cnt <= 2'(LAT - 2);
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (start) frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // out_data is the head register; tail holds the second entry when full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      tail     <= '0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            out_data <= word;
            count    <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            out_data <= word;
          end else if (push) begin
            tail  <= word;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            out_data <= tail;
            if (push) tail <= word;
            else count <= 2'd1;
          end else if (push) begin
            overflow <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
